// File: rtl/mdu_controller.sv
// Issue-side controller for the multi-cycle multiply/divide unit.
// Handles divide-by-zero, signed overflow and the MULHSU sign fixup without the unit.
module mdu_controller #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             req_valid,
   input  logic [2:0]       req_funct3,
   input  logic [WIDTH-1:0] req_rs1,
   input  logic [WIDTH-1:0] req_rs2,
   input  logic             flush,
   output logic             stall,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_data,
   output logic             mc_reset,
   output logic             mc_start,
   output logic [1:0]       mc_op,
   output logic [WIDTH-1:0] mc_operand1,
   output logic [WIDTH-1:0] mc_operand2,
   input  logic [WIDTH-1:0] mc_result1,
   input  logic [WIDTH-1:0] mc_result2,
   input  logic             mc_busy
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE,
      DRAIN
   } state_t;

   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   state_t           state;
   logic             sel_hi;
   logic             is_mulhsu;
   logic             done_valid;
   logic             div_by_zero;
   logic             sig_ovf;
   logic             special;
   logic [WIDTH-1:0] special_data;
   logic [WIDTH-1:0] mulhsu_adj;
   logic [WIDTH-1:0] unit_data;

   assign div_by_zero = req_funct3[2] && (req_rs2 == '0);
   assign sig_ovf     = req_funct3[2] && !req_funct3[0] &&
                        (req_rs1 == MIN_NEG) && (req_rs2 == ALL_ONES);
   assign special     = div_by_zero || sig_ovf;

   // funct3[1] separates remainder from quotient for the divide group
   always_comb begin
      special_data = '0;
      if (div_by_zero) begin
         special_data = req_funct3[1] ? req_rs1 : ALL_ONES;
      end else if (sig_ovf) begin
         special_data = req_funct3[1] ? '0 : MIN_NEG;
      end
   end

   // MULHSU runs as an unsigned multiply; a negative rs1 over-counts rs2 * 2^32
   assign mulhsu_adj = mc_operand1[WIDTH-1] ? mc_operand2 : '0;

   always_comb begin
      unit_data = mc_result1;
      if (sel_hi) begin
         unit_data = is_mulhsu ? (mc_result2 - mulhsu_adj) : mc_result2;
      end
   end

   assign stall      = req_valid && (state != DONE) && !flush;
   assign resp_valid = done_valid && !flush;
   assign mc_reset   = ~RESET;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state       <= IDLE;
         mc_start    <= 1'b0;
         done_valid  <= 1'b0;
         resp_data   <= '0;
         mc_op       <= 2'b00;
         mc_operand1 <= '0;
         mc_operand2 <= '0;
         sel_hi      <= 1'b0;
         is_mulhsu   <= 1'b0;
      end else begin
         mc_start   <= 1'b0;
         done_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && !flush) begin
                  if (special) begin
                     resp_data  <= special_data;
                     done_valid <= 1'b1;
                     state      <= DONE;
                  end else begin
                     mc_operand1 <= req_rs1;
                     mc_operand2 <= req_rs2;
                     mc_op       <= {req_funct3[2],
                                     req_funct3[2] ? req_funct3[0] : req_funct3[1]};
                     sel_hi      <= req_funct3[2] ? req_funct3[1]
                                                  : (req_funct3[1] | req_funct3[0]);
                     is_mulhsu   <= (req_funct3 == 3'b010);
                     mc_start    <= 1'b1;
                     state       <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               state <= flush ? DRAIN : WAIT;
            end
            WAIT: begin
               if (flush) begin
                  state <= DRAIN;
               end else if (!mc_busy) begin
                  resp_data  <= unit_data;
                  done_valid <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            DRAIN: begin
               if (!mc_busy) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_controller.sv
// Directed bench for mdu_controller with a behavioural multi-cycle unit behind it.
module tb_mdu_controller;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        req_valid;
   logic [2:0]  req_funct3;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic        flush;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        mc_reset;
   logic        mc_start;
   logic [1:0]  mc_op;
   logic [31:0] mc_operand1;
   logic [31:0] mc_operand2;
   logic [31:0] mc_result1 = '0;
   logic [31:0] mc_result2 = '0;
   logic        mc_busy = 1'b0;

   int compare_count  = 0;
   int mismatch_count = 0;

   mdu_controller #(.WIDTH(32)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .req_valid   (req_valid),
      .req_funct3  (req_funct3),
      .req_rs1     (req_rs1),
      .req_rs2     (req_rs2),
      .flush       (flush),
      .stall       (stall),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .mc_reset    (mc_reset),
      .mc_start    (mc_start),
      .mc_op       (mc_op),
      .mc_operand1 (mc_operand1),
      .mc_operand2 (mc_operand2),
      .mc_result1  (mc_result1),
      .mc_result2  (mc_result2),
      .mc_busy     (mc_busy)
   );

   always #5 CLK = ~CLK;

   // Unit model: busy for unit_lat cycles after Start, results garbage until done
   int          unit_lat = 4;
   int          unit_cnt = 0;
   logic [31:0] pend1 = '0;
   logic [31:0] pend2 = '0;

   function automatic logic [63:0] unitCompute(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
      longint sa;
      longint sb;
      int     qa;
      int     qb;
      logic [63:0] res;
      res = '0;
      case (op)
         2'b00: begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            res = sa * sb;
         end
         2'b01: res = {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 32'd0) begin
               res = {a, 32'hFFFFFFFF};
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               res = {32'h0, 32'h80000000};
            end else begin
               qa  = $signed(a);
               qb  = $signed(b);
               res = {qa % qb, qa / qb};
            end
         end
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFFFFFF};
            else            res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   always @(posedge CLK) begin
      if (mc_reset) begin
         mc_busy    <= 1'b0;
         unit_cnt   <= 0;
         mc_result1 <= '0;
         mc_result2 <= '0;
      end else if (mc_start) begin
         mc_busy        <= 1'b1;
         unit_cnt       <= unit_lat;
         mc_result1     <= 32'hDEADBEEF;
         mc_result2     <= 32'hDEADBEEF;
         {pend2, pend1} <= unitCompute(mc_op, mc_operand1, mc_operand2);
      end else if (unit_cnt > 0) begin
         unit_cnt <= unit_cnt - 1;
         if (unit_cnt == 1) begin
            mc_busy    <= 1'b0;
            mc_result1 <= pend1;
            mc_result2 <= pend2;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // One full request; normal ops with unit_lat=4 finish 7 cycles after acceptance
   task automatic applyStimulus(input string tag, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expected, input bit special,
                                input logic [1:0] exp_op);
      int          cycles;
      int          starts;
      bit          got;
      bit          stall_err;
      logic [1:0]  seen_op;
      logic [31:0] seen_a;
      logic [31:0] seen_b;
      cycles = 0; starts = 0; got = 1'b0; stall_err = 1'b0;
      seen_op = '0; seen_a = '0; seen_b = '0;
      @(negedge CLK);
      req_valid  = 1'b1;
      req_funct3 = f3;
      req_rs1    = a;
      req_rs2    = b;
      #1;
      if (!stall) stall_err = 1'b1;
      while (!got && cycles < 100) begin
         @(negedge CLK);
         cycles++;
         if (mc_start) begin
            starts++;
            seen_op = mc_op;
            seen_a  = mc_operand1;
            seen_b  = mc_operand2;
         end
         if (resp_valid) begin
            got = 1'b1;
            if (stall) stall_err = 1'b1;
         end else if (!stall) begin
            stall_err = 1'b1;
         end
      end
      checkOutput({tag, "_resp_valid"}, 32'(got), 32'd1);
      checkOutput({tag, "_data"}, resp_data, expected);
      checkOutput({tag, "_latency"}, cycles, special ? 32'd1 : 32'd7);
      checkOutput({tag, "_starts"}, starts, special ? 32'd0 : 32'd1);
      checkOutput({tag, "_stall"}, 32'(stall_err), 32'd0);
      if (!special) begin
         checkOutput({tag, "_op"}, 32'(seen_op), 32'(exp_op));
         checkOutput({tag, "_operand1"}, seen_a, a);
         checkOutput({tag, "_operand2"}, seen_b, b);
      end
      req_valid = 1'b0;
   endtask

   int cycles;
   int starts;
   int bad_resp;
   bit got;

   initial begin
      RESET = 1'b0; req_valid = 1'b0; req_funct3 = '0;
      req_rs1 = '0; req_rs2 = '0; flush = 1'b0;
      repeat (3) @(negedge CLK);
      checkOutput("rst_mc_reset", 32'(mc_reset), 32'd1);
      checkOutput("rst_mc_start", 32'(mc_start), 32'd0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_resp_data", resp_data, 32'd0);
      checkOutput("rst_mc_op", 32'(mc_op), 32'd0);
      checkOutput("rst_operand1", mc_operand1, 32'd0);
      checkOutput("rst_operand2", mc_operand2, 32'd0);
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      checkOutput("run_mc_reset", 32'(mc_reset), 32'd0);

      applyStimulus("mul",    3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 2'b00);
      applyStimulus("mulh",   3'b001, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 2'b00);
      applyStimulus("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 2'b01);
      applyStimulus("mulhu",  3'b011, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 2'b01);
      applyStimulus("div",    3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 2'b10);
      applyStimulus("rem",    3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 2'b10);
      applyStimulus("divu",   3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 2'b11);
      applyStimulus("remu",   3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 2'b11);
      applyStimulus("divu_minneg", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 2'b11);
      applyStimulus("remu_minneg", 3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 2'b11);

      applyStimulus("div_by0",  3'b100, 32'h00001234, 32'd0, 32'hFFFFFFFF, 1'b1, 2'b00);
      applyStimulus("divu_by0", 3'b101, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b1, 2'b00);
      applyStimulus("rem_by0",  3'b110, 32'h00001234, 32'd0, 32'h00001234, 1'b1, 2'b00);
      applyStimulus("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 1'b1, 2'b00);
      applyStimulus("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 2'b00);
      applyStimulus("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, 2'b00);

      // DIVU squashed in WAIT; the MUL behind it waits out the drain
      @(negedge CLK);
      req_valid = 1'b1; req_funct3 = 3'b101; req_rs1 = 32'd100; req_rs2 = 32'd7;
      @(negedge CLK);
      checkOutput("flush_issue_start", 32'(mc_start), 32'd1);
      @(negedge CLK);
      flush = 1'b1;
      #1;
      checkOutput("flush_stall_low", 32'(stall), 32'd0);
      @(negedge CLK);
      flush = 1'b0; req_funct3 = 3'b000; req_rs1 = 32'd3; req_rs2 = 32'd4;
      #1;
      checkOutput("drain_stall", 32'(stall), 32'd1);
      checkOutput("drain_resp_valid", 32'(resp_valid), 32'd0);
      cycles = 0; starts = 0; bad_resp = 0; got = 1'b0;
      while (!got && cycles < 100) begin
         @(negedge CLK);
         cycles++;
         if (mc_start) starts++;
         if (resp_valid) begin
            if (starts == 0) bad_resp++;
            else got = 1'b1;
         end
      end
      req_valid = 1'b0;
      checkOutput("flush_no_resp", bad_resp, 32'd0);
      checkOutput("flush_mul_valid", 32'(got), 32'd1);
      checkOutput("flush_mul_data", resp_data, 32'd12);
      checkOutput("flush_mul_starts", starts, 32'd1);
      checkOutput("flush_mul_latency", cycles, 32'd11);

      // Flush in DONE suppresses the response; flush in IDLE ignores the request
      @(negedge CLK);
      req_valid = 1'b1; req_funct3 = 3'b100; req_rs1 = 32'h00001234; req_rs2 = 32'd0;
      @(negedge CLK);
      flush = 1'b1;
      #1;
      checkOutput("done_flush_resp", 32'(resp_valid), 32'd0);
      req_funct3 = 3'b000; req_rs1 = 32'd2; req_rs2 = 32'd2;
      @(negedge CLK);
      #1;
      checkOutput("idle_flush_stall", 32'(stall), 32'd0);
      @(negedge CLK);
      checkOutput("idle_flush_start", 32'(mc_start), 32'd0);
      checkOutput("idle_flush_resp", 32'(resp_valid), 32'd0);
      flush = 1'b0; req_valid = 1'b0;

      // Reset mid-WAIT of a DIVU
      @(negedge CLK);
      req_valid = 1'b1; req_funct3 = 3'b101; req_rs1 = 32'd100; req_rs2 = 32'd7;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0; req_valid = 1'b0;
      #1;
      checkOutput("midrst_mc_reset_now", 32'(mc_reset), 32'd1);
      @(negedge CLK);
      checkOutput("midrst_mc_start", 32'(mc_start), 32'd0);
      checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("midrst_resp_data", resp_data, 32'd0);
      checkOutput("midrst_mc_op", 32'(mc_op), 32'd0);
      checkOutput("midrst_operand1", mc_operand1, 32'd0);
      checkOutput("midrst_operand2", mc_operand2, 32'd0);
      checkOutput("midrst_mc_reset", 32'(mc_reset), 32'd1);
      @(negedge CLK);
      RESET = 1'b1;
      bad_resp = 0;
      repeat (6) begin
         @(negedge CLK);
         if (resp_valid || mc_start) bad_resp++;
      end
      checkOutput("midrst_quiet", bad_resp, 32'd0);
      applyStimulus("mul_after_rst", 3'b000, 32'd5, 32'd6, 32'd30, 1'b0, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
